// File: rtl/disparity_wta_selector.sv
// rtl/disparity_wta_selector.sv - winner-take-all disparity selector after the SSD cost engine
module disparity_wta_selector #(
  parameter int MAX_DISP    = 64,
  parameter int COST_WIDTH  = 20,
  parameter int COST_THRESH = 20000,
  parameter int MIN_MARGIN  = 512
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic [COST_WIDTH-1:0]       cost_in,
  input  logic                        valid_in,
  input  logic                        first_in,
  input  logic                        clear_err_in,
  output logic                        valid_out,
  output logic [$clog2(MAX_DISP)-1:0] disp_out,
  output logic [COST_WIDTH-1:0]       cost_out,
  output logic                        confident_out,
  output logic                        error_out
);

  localparam int DW = $clog2(MAX_DISP);
  localparam int CW = DW + 1;
  localparam logic [COST_WIDTH-1:0] THRESH_C = COST_WIDTH'(COST_THRESH);
  localparam logic [COST_WIDTH:0]   MARGIN_C = (COST_WIDTH+1)'(MIN_MARGIN);
  localparam logic [CW-1:0]         LAST_C   = CW'(MAX_DISP - 1);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [COST_WIDTH-1:0] best, second;
  logic [DW-1:0]         best_idx;
  logic [CW-1:0]         cnt;

  logic                  load_first, load_beat, finish, err_set;
  logic [COST_WIDTH-1:0] best_nxt, second_nxt;
  logic [DW-1:0]         idx_nxt;
  logic [COST_WIDTH:0]   margin;
  logic                  confident_nxt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_in && first_in) state_nxt = ACCUM;
      ACCUM:   if (valid_in && !first_in && cnt == LAST_C) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A first_in beat always (re)starts a pixel; in ACCUM it also flags the aborted one.
  always_comb begin
    load_first = valid_in && first_in;
    load_beat  = (state == ACCUM) && valid_in && !first_in;
    finish     = load_beat && (cnt == LAST_C);
    err_set    = valid_in && ((state == IDLE) ? !first_in : first_in);
  end

  // Strict less-than keeps the lowest disparity on ties.
  always_comb begin
    best_nxt   = best;
    second_nxt = second;
    idx_nxt    = best_idx;
    if (cost_in < best) begin
      best_nxt   = cost_in;
      second_nxt = best;
      idx_nxt    = cnt[DW-1:0];
    end else if (cost_in < second) begin
      second_nxt = cost_in;
    end
    margin        = {1'b0, second_nxt} - {1'b0, best_nxt};
    confident_nxt = (best_nxt <= THRESH_C) && (margin >= MARGIN_C);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      best     <= '0;
      second   <= '0;
      best_idx <= '0;
      cnt      <= '0;
    end else if (load_first) begin
      best     <= cost_in;
      second   <= '1;
      best_idx <= '0;
      cnt      <= CW'(1);
    end else if (load_beat) begin
      best     <= best_nxt;
      second   <= second_nxt;
      best_idx <= idx_nxt;
      cnt      <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_out     <= 1'b0;
      disp_out      <= '0;
      cost_out      <= '0;
      confident_out <= 1'b0;
    end else begin
      valid_out <= finish;
      if (finish) begin
        disp_out      <= idx_nxt;
        cost_out      <= best_nxt;
        confident_out <= confident_nxt;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)         error_out <= 1'b0;
    else if (err_set)      error_out <= 1'b1;
    else if (clear_err_in) error_out <= 1'b0;
  end

endmodule

// File: tb/tb_disparity_wta_selector.sv
// tb/tb_disparity_wta_selector.sv - self-checking bench for disparity_wta_selector
module tb_disparity_wta_selector;

  localparam int MD = 4;
  localparam int CWD = 20;
  localparam int THR = 100;
  localparam int MRG = 10;

  logic           clk_in = 1'b0;
  logic           rst_n_in = 1'b0;
  logic [CWD-1:0] cost_in = '0;
  logic           valid_in = 1'b0;
  logic           first_in = 1'b0;
  logic           clear_err_in = 1'b0;
  logic           valid_out;
  logic [1:0]     disp_out;
  logic [CWD-1:0] cost_out;
  logic           confident_out;
  logic           error_out;

  typedef struct {
    int d;
    int c;
    int f;
  } res_t;

  res_t resq[$];
  int   vo_count = 0;
  int   tests = 0;
  int   fails = 0;

  disparity_wta_selector #(
    .MAX_DISP(MD), .COST_WIDTH(CWD), .COST_THRESH(THR), .MIN_MARGIN(MRG)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .cost_in(cost_in), .valid_in(valid_in),
    .first_in(first_in), .clear_err_in(clear_err_in), .valid_out(valid_out),
    .disp_out(disp_out), .cost_out(cost_out), .confident_out(confident_out),
    .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (valid_out === 1'b1) begin
      res_t r;
      r.d = int'(disp_out);
      r.c = int'(cost_out);
      r.f = int'(confident_out);
      vo_count++;
      resq.push_back(r);
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: winner is the lowest index holding the minimum; runner-up is the
  // second entry of the sorted multiset of costs.
  task automatic model(input int c[MD], output int d, output int bc, output int cf);
    int q[$];
    for (int i = 0; i < MD; i++) q.push_back(c[i]);
    q.sort();
    bc = q[0];
    d = -1;
    for (int i = MD - 1; i >= 0; i--) if (c[i] == bc) d = i;
    cf = ((bc <= THR) && ((q[1] - bc) >= MRG)) ? 1 : 0;
  endtask

  task automatic beat(input int c, input bit f);
    @(negedge clk_in);
    valid_in = 1'b1;
    first_in = f;
    cost_in = CWD'(c);
    clear_err_in = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk_in);
    valid_in = 1'b0;
    first_in = 1'b0;
    clear_err_in = 1'b0;
  endtask

  task automatic send(input int c[MD], input int gapmax);
    for (int i = 0; i < MD; i++) begin
      beat(c[i], i == 0);
      if (i < MD - 1) repeat ($urandom_range(0, gapmax)) idle();
    end
  endtask

  task automatic expect_pixel(input string tag, input int c[MD]);
    int d, bc, cf;
    res_t r;
    #1;
    model(c, d, bc, cf);
    chk({tag, "_avail"}, resq.size() > 0, 1);
    if (resq.size() > 0) begin
      r = resq.pop_front();
      chk({tag, "_disp"}, r.d, d);
      chk({tag, "_cost"}, r.c, bc);
      chk({tag, "_conf"}, r.f, cf);
    end
  endtask

  initial begin
    int px[MD];
    int pb[MD];
    int n0;
    int nexp;

    #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_disp", disp_out, 0);
    chk("rst_cost", cost_out, 0);
    chk("rst_conf", confident_out, 0);
    chk("rst_err", error_out, 0);
    repeat (2) idle();
    rst_n_in = 1'b1;
    idle();

    px = '{50, 30, 70, 40};
    send(px, 0);
    idle();
    #1 chk("t2_pulse", valid_out, 1);
    expect_pixel("t2", px);
    idle();
    #1 chk("t2_pulse_end", valid_out, 0);
    chk("t2_hold_cost", cost_out, 30);

    // Reset in the middle of a pixel.
    n0 = vo_count;
    beat(5, 1'b1);
    beat(6, 1'b0);
    @(negedge clk_in);
    valid_in = 1'b0;
    rst_n_in = 1'b0;
    #1;
    chk("t1_cost0", cost_out, 0);
    chk("t1_disp0", disp_out, 0);
    chk("t1_conf0", confident_out, 0);
    repeat (2) idle();
    rst_n_in = 1'b1;
    repeat (3) idle();
    #1;
    chk("t1_no_out", vo_count, n0);
    chk("t1_err", error_out, 0);
    send(px, 0);
    idle();
    expect_pixel("t1_clean", px);

    px = '{30, 80, 30, 35};
    send(px, 0);
    idle();
    expect_pixel("t3_tie", px);
    px = '{200, 150, 120, 110};
    send(px, 0);
    idle();
    expect_pixel("t3_thr", px);

    px = '{9, 5, 7, 3};
    send(px, 3);
    idle();
    expect_pixel("t4_gaps", px);
    n0 = vo_count;
    pb = '{60, 61, 90, 2};
    send(px, 0);
    send(pb, 0);
    idle();
    #1 chk("t4_b2b_count", vo_count - n0, 2);
    expect_pixel("t4_b2b_a", px);
    expect_pixel("t4_b2b_b", pb);

    // Abort by a fresh first_in inside a pixel.
    n0 = vo_count;
    beat(10, 1'b1);
    beat(20, 1'b0);
    px = '{4, 8, 6, 90};
    send(px, 0);
    idle();
    #1 chk("t5_one_out", vo_count - n0, 1);
    chk("t5_err", error_out, 1);
    expect_pixel("t5", px);
    repeat (3) idle();
    #1 chk("t5_err_sticky", error_out, 1);
    @(negedge clk_in);
    clear_err_in = 1'b1;
    idle();
    #1 chk("t5_err_clr", error_out, 0);

    n0 = vo_count;
    beat(7, 1'b0);
    idle();
    repeat (2) idle();
    #1 chk("t6_err", error_out, 1);
    chk("t6_no_out", vo_count, n0);
    @(negedge clk_in);
    clear_err_in = 1'b1;
    idle();
    #1 chk("t6_err_clr", error_out, 0);
    @(negedge clk_in);
    valid_in = 1'b1;
    first_in = 1'b0;
    cost_in = CWD'(5);
    clear_err_in = 1'b1;
    idle();
    #1 chk("t6_set_wins", error_out, 1);
    @(negedge clk_in);
    clear_err_in = 1'b1;
    idle();

    n0 = vo_count;
    nexp = 0;
    for (int k = 0; k < 30; k++) begin
      int hi;
      hi = (k % 3 == 0) ? 25 : 140;
      for (int i = 0; i < MD; i++) px[i] = $urandom_range(0, hi);
      send(px, 2);
      idle();
      nexp++;
      expect_pixel("rnd", px);
      repeat ($urandom_range(0, 1)) idle();
    end
    idle();
    #1;
    chk("rnd_count", vo_count - n0, nexp);
    chk("rnd_err", error_out, 0);
    chk("queue_empty", resq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
